// File: rtl/lms_i2s_tx_if.sv
// Sample input bus of the I2S transmitter: filtered word plus one-cycle write strobe.
interface lms_i2s_tx_if #(
  parameter int SAMPLE_SIZE = 16
);
  logic [SAMPLE_SIZE-1:0] din;
  logic                   valid_in;

  modport master (output din, output valid_in);
  modport slave  (input  din, input  valid_in);
endinterface

// File: rtl/lms_i2s_tx.sv
// I2S master transmitter: buffers mono samples in a small FIFO and sends each
// word MSB-first in both left and right slots, with all link clocks derived
// from clk. Underrun and overrun are reported as sticky flags.
module lms_i2s_tx #(
  parameter int SAMPLE_SIZE = 16,
  parameter int SLOT_BITS   = 32,
  parameter int BCLK_HALF   = 18,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic                          clr_flags,
  lms_i2s_tx_if.slave                   smp,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          overrun
);

  localparam int PW = $clog2(2 * SLOT_BITS);
  localparam int SW = $clog2(SLOT_BITS);
  localparam int CW = $clog2(BCLK_HALF);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [PW-1:0] P_LAST = PW'(2 * SLOT_BITS - 1);

  logic [CW-1:0]          cnt;
  logic [PW-1:0]          p;
  logic [PW-1:0]          p_next;
  logic [PW-1:0]          p_slot;
  logic [SW-1:0]          bit_idx;
  logic [SLOT_BITS-1:0]   slot_word;
  logic [SAMPLE_SIZE-1:0] cur_word;
  logic [SAMPLE_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic                   tc;
  logic                   fall;
  logic                   load;
  logic                   pop;
  logic                   push;
  logic                   full;
  logic                   empty;
  logic                   lr_next;
  logic                   bit_next;

  // Decode the fall event, next bit position, and the next slot bit/word-select.
  always_comb begin
    tc        = (cnt == CW'(BCLK_HALF - 1));
    fall      = en && tc && bclk;
    p_next    = (p == P_LAST) ? '0 : p + 1'b1;
    p_slot    = (p_next >= PW'(SLOT_BITS)) ? p_next - PW'(SLOT_BITS) : p_next;
    bit_idx   = SW'(SLOT_BITS - 1) - SW'(p_slot);
    slot_word = SLOT_BITS'(cur_word) << (SLOT_BITS - SAMPLE_SIZE);
    bit_next  = slot_word[bit_idx];
    lr_next   = (p_next >= PW'(SLOT_BITS - 1)) && (p_next <= PW'(2 * SLOT_BITS - 2));
    load      = fall && (p_next == P_LAST);
    full      = (fifo_level == LW'(FIFO_DEPTH));
    empty     = (fifo_level == '0);
    pop       = load && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    push      = smp.valid_in && (!full || pop);
  end

  // Bit-clock divider and serial link outputs; en low parks the link at frame start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      sdata <= 1'b0;
      p     <= P_LAST;
    end else if (!en) begin
      cnt   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      sdata <= 1'b0;
      p     <= P_LAST;
    end else if (tc) begin
      cnt  <= '0;
      bclk <= ~bclk;
      if (bclk) begin
        p     <= p_next;
        lrclk <= lr_next;
        sdata <= bit_next;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame word register: reloaded at the last bit of each frame, zero on underrun.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_word <= '0;
    end else if (load) begin
      cur_word <= pop ? mem[rptr] : '0;
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= smp.din;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky error flags; a set event overrides a clear in the same cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load && empty)                        underrun <= 1'b1;
      else if (clr_flags)                       underrun <= 1'b0;
      if (smp.valid_in && full && !pop)         overrun  <= 1'b1;
      else if (clr_flags)                       overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lms_i2s_tx.sv
// Bench for lms_i2s_tx: a queue-based reference model predicts the words that
// each slot must carry; a monitor decodes the I2S stream and checks them.
module tb_lms_i2s_tx;
  localparam int S  = 16;
  localparam int SS = 16;
  localparam int BH = 2;
  localparam int D  = 4;
  localparam int FR = 2 * S * 2 * BH;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       en = 1'b0;
  logic       clr_flags = 1'b0;
  logic       bclk, lrclk, sdata, underrun, overrun;
  logic [2:0] fifo_level;

  lms_i2s_tx_if #(.SAMPLE_SIZE(SS)) smp ();

  lms_i2s_tx #(.SAMPLE_SIZE(SS), .SLOT_BITS(S), .BCLK_HALF(BH), .FIFO_DEPTH(D)) dut (
    .clk(clk), .nrst(nrst), .en(en), .clr_flags(clr_flags), .smp(smp),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .fifo_level(fifo_level),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SS-1:0] mq[$];
  logic [S:0]    exp_q[$];
  logic [SS-1:0] m_cur = '0;
  logic          m_uf = 1'b0;
  logic          m_of = 1'b0;
  int            ec = 0;
  int            m_p = 2 * S - 1;

  initial begin
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        mq.delete(); exp_q.delete();
        m_cur = '0; m_uf = 1'b0; m_of = 1'b0; ec = 0; m_p = 2 * S - 1;
      end else begin
        if (clr_flags) begin m_uf = 1'b0; m_of = 1'b0; end
        if (en) begin
          ec++;
          if (ec % (2 * BH) == 0) begin
            m_p = (ec / (2 * BH) - 1) % (2 * S);
            if (m_p == S - 1) exp_q.push_back({1'b0, m_cur});
            if (m_p == 2 * S - 1) begin
              exp_q.push_back({1'b1, m_cur});
              if (mq.size() > 0) m_cur = mq.pop_front();
              else begin m_cur = '0; m_uf = 1'b1; end
            end
          end
        end else begin
          ec = 0; m_p = 2 * S - 1;
        end
        if (smp.valid_in) begin
          if (mq.size() < D) mq.push_back(smp.din);
          else m_of = 1'b1;
        end
      end
    end
  end

  function automatic bit next_is_load();
    int e;
    e = ec + 1;
    return en && (e % (2 * BH) == 0) && (((e / (2 * BH)) - 1) % (2 * S) == 2 * S - 1);
  endfunction

  // ---------------- monitor ----------------
  logic [S-1:0] sh = '0;
  logic         prev_b = 1'b0;
  logic         prev_lr = 1'b0;
  int           mcnt = -1;
  int           cyc = 0;
  int           last_rise = -1;

  initial begin
    logic [S:0] e;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        mcnt = -1; prev_b = 1'b0; prev_lr = 1'b0; last_rise = -1;
      end else begin
        cyc++;
        if (ec == 0) begin mcnt = -1; prev_lr = 1'b0; last_rise = -1; end
        if (bclk && !prev_b) begin
          if (last_rise >= 0) check("bclk_period", cyc - last_rise, 2 * BH);
          last_rise = cyc;
          sh = {sh[S-2:0], sdata};
          mcnt++;
          if (lrclk !== prev_lr) begin
            if (mcnt == S) begin
              if (exp_q.size() == 0) check("unexpected_slot", {prev_lr, sh}, 32'hDEAD);
              else begin
                e = exp_q.pop_front();
                check(prev_lr ? "right_word" : "left_word", {prev_lr, sh}, e);
              end
            end
            mcnt = 0;
          end
          prev_lr = lrclk;
        end
        prev_b = bclk;
        check("fifo_level", fifo_level, mq.size());
        check("underrun", underrun, m_uf);
        check("overrun", overrun, m_of);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic write(input logic [SS-1:0] w);
    @(negedge clk); smp.din = w; smp.valid_in = 1'b1;
    @(negedge clk); smp.valid_in = 1'b0;
  endtask

  task automatic pulse_clr();
    do @(negedge clk); while (next_is_load());
    clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FR) @(negedge clk);
  endtask

  task automatic wait_p(input int target);
    bit found = 0;
    int i = 0;
    while (!found && i < 3 * FR) begin
      @(negedge clk);
      if (ec != 0 && m_p == target) found = 1;
      i++;
    end
    if (!found) check("wait_p_timeout", 0, 1);
  endtask

  task automatic pulse_on_load(input logic [SS-1:0] w);
    bit found = 0;
    int i = 0;
    while (!found && i < 3 * FR) begin
      @(negedge clk);
      if (next_is_load()) begin smp.din = w; smp.valid_in = 1'b1; found = 1; end
      i++;
    end
    if (!found) check("load_timeout", 0, 1);
    @(negedge clk); smp.valid_in = 1'b0;
  endtask

  task automatic drop_en_at_p10();
    int lvl;
    wait_p(10);
    lvl = mq.size();
    en = 1'b0;
    @(negedge clk);
    check("idle_bclk", bclk, 0);
    check("idle_lrclk", lrclk, 0);
    check("idle_sdata", sdata, 0);
    check("idle_level_kept", fifo_level, lvl);
  endtask

  initial begin
    smp.din = '0; smp.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // single word then running dry
    write(16'hA5C3);
    en = 1'b1;
    wait_frames(1);
    repeat (8) @(negedge clk);
    check("single_no_underrun", underrun, 0);
    wait_frames(2);
    check("underrun_set", underrun, 1);
    pulse_clr();
    check("underrun_cleared", underrun, 0);
    wait_frames(1);

    drop_en_at_p10();

    // overrun with link idle
    pulse_clr();
    for (int i = 1; i <= 5; i++) write(SS'(i));
    check("ovr_level", fifo_level, 4);
    check("ovr_flag", overrun, 1);
    pulse_clr();
    check("ovr_cleared", overrun, 0);

    // write coinciding with pop while full
    en = 1'b1;
    pulse_on_load(16'h0006);
    check("full_wr_pop_level", fifo_level, 4);
    check("full_wr_pop_overrun", overrun, 0);
    check("full_wr_pop_underrun", underrun, 0);
    wait_frames(6);

    // write coinciding with load while empty
    pulse_clr();
    pulse_on_load(16'h0007);
    check("empty_wr_pop_underrun", underrun, 1);
    check("empty_wr_pop_level", fifo_level, 1);
    wait_frames(2);

    // randomized traffic
    for (int i = 0; i < 8 * FR; i++) begin
      @(negedge clk);
      smp.valid_in = ($urandom_range(0, 29) == 0);
      smp.din      = SS'($urandom);
      clr_flags    = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); smp.valid_in = 1'b0; clr_flags = 1'b0;
    wait_frames(1);

    // abort mid-frame, then replay of the held word on re-enable
    drop_en_at_p10();
    write(16'h3C5A);
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_frames(3);
    drop_en_at_p10();
    repeat (10) @(negedge clk);
    check("all_slots_seen", exp_q.size(), 0);

    // asynchronous reset while running
    en = 1'b1;
    write(16'h1234);
    write(16'h4321);
    repeat (FR + FR / 2) @(negedge clk);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("arst_bclk", bclk, 0);
    check("arst_lrclk", lrclk, 0);
    check("arst_sdata", sdata, 0);
    check("arst_level", fifo_level, 0);
    check("arst_underrun", underrun, 0);
    check("arst_overrun", overrun, 0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lms_i2s_tx.md
Name: lms_i2s_tx

Overview:
- Output-side audio transmitter for the LMS adaptive filter chain.
- Accepts filtered samples (`out`/`valid_out` of the filter) on a one-cycle valid pulse and buffers them in a small FIFO.
- Serializes each sample MSB-first onto an I2S master link (bclk, lrclk, sdata), carrying the same mono word in both left and right slots.
- Generates all I2S clocks from the system clock; reports FIFO underrun and overrun as sticky flags.

Parameters:
- SAMPLE_SIZE, 16, width of input sample word; must be <= SLOT_BITS.
- SLOT_BITS, 32, bclk periods per channel slot; frame = 2*SLOT_BITS bclk periods.
- BCLK_HALF, 18, clk cycles per bclk half-period; must be >= 2.
- FIFO_DEPTH, 4, sample FIFO depth; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  transmitter enable; 0 = link idle.
- din  in  SAMPLE_SIZE  sample word, two's complement.
- valid_in  in  1  one-cycle write strobe for din.
- clr_flags  in  1  synchronous clear of underrun/overrun.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0 = left slot, 1 = right slot.
- sdata  out  1  I2S serial data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  out  1  sticky: frame started with FIFO empty.
- overrun  out  1  sticky: write dropped because FIFO full.

Behaviour:
- Reset: all outputs 0, FIFO empty, cur_word=0, bit position p=2*SLOT_BITS-1, half-period counter 0. All outputs are registered.
- Idle (en=0): bclk, lrclk and sdata forced to 0 on the next clk edge. p is reloaded to 2*SLOT_BITS-1 and the half-period counter to 0. FIFO writes are still accepted and FIFO contents are retained. Deasserting en mid-frame aborts the frame immediately; no pop occurs.
- Bclk generation (en=1): the half-period counter counts 0..BCLK_HALF-1. At terminal count bclk toggles. The first toggle after en rises is rising. The 1->0 toggle cycle is a "fall event".
- On each fall event:
  - p <= (p+1) mod 2*SLOT_BITS.
  - lrclk <= 1 iff the new p is in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0. lrclk therefore leads each slot by one bclk (I2S delay).
  - sdata <= bit (SLOT_BITS-1-(p mod SLOT_BITS)) of the slot word, where slot word = {cur_word, (SLOT_BITS-SAMPLE_SIZE) zeros}.
  - sdata, lrclk and bclk all change on the same clk edge.
- Word load: on the fall event entering p=2*SLOT_BITS-1, the FIFO is popped into cur_word if non-empty. If empty, cur_word <= 0 and underrun <= 1. cur_word feeds both slots of the following frame (p=0..2*SLOT_BITS-1).
- First frame after en rises: the first fall event enters p=0 (reload value 2*SLOT_BITS-1 plus 1). No pop occurs; that frame transmits the current cur_word. The first pop happens at the end of that frame.
- FIFO write: if valid_in=1 and the FIFO is not full, din is written. If full, din is dropped and overrun <= 1.
  - Write and pop in the same cycle while full: the write is accepted and the level is unchanged.
  - Write and pop in the same cycle while empty: no bypass. The pop sees empty (underrun set, cur_word=0) and the write is stored; level becomes 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level reflects the state after the clk edge.
- Flags: clr_flags=1 clears both flags in that cycle. A set event in the same cycle wins (flag ends 1).
- Latency: a sample written into an empty FIFO while running reaches sdata (MSB) at the start of the frame after the next p=2*SLOT_BITS-1 load.

Test Plan:
(All scenarios use SLOT_BITS=16, SAMPLE_SIZE=16, BCLK_HALF=2, FIFO_DEPTH=4.)
- Reset mid-frame: assert nrst=0 while running -> bclk, lrclk, sdata, fifo_level, underrun and overrun read 0 within the same cycle, asynchronously.
- Single word: write din=16'hA5C3, en=1 -> first frame all zeros with underrun=0. Next frame: lrclk=0 for 16 bclk with sdata=A5C3 MSB-first starting one bclk after the lrclk fall, then lrclk=1 with A5C3 repeated. bclk period = 4 clk.
- Underrun: en=1 with empty FIFO for 2 frames -> sdata all 0; underrun=1 after the first load point; clr_flags clears it to 0.
- Overrun: 5 writes (1,2,3,4,5) with en=0 -> fifo_level=4, overrun=1; after enabling, frames carry 1,2,3,4 and 5 never appears.
- Simultaneous write/pop: with FIFO full, pulse valid_in on the load cycle -> word accepted, fifo_level stays 4, overrun=0. With FIFO empty, the same stimulus gives underrun=1 and fifo_level=1.
- en drop mid-frame at p=10 -> outputs 0 next cycle and FIFO level unchanged. On re-enable, the first frame replays the previous cur_word.
